// File: rtl/issue_instr_buffer_if.sv
// ---------------------------------------------------------------------------
// issue_instr_buffer_if
//
// Bundles the decode-side push handshake, the issue-side pop handshake and
// the flush / branch-resolution controls of the decoded-instruction buffer.
//
// Signals (direction as seen by the buffer, i.e. the slave modport):
//   flush_i                 in   full flush (FIFO and branch-pending state)
//   flush_unissued_instr_i  in   empty the FIFO only
//   decoded_instr_i         in   decoded instruction (scoreboard entry)
//   decoded_instr_valid_i   in   decoded_instr_i is valid
//   is_ctrl_flow_i          in   decoded_instr_i is a branch or jump
//   decoded_instr_ack_o     out  instruction accepted this cycle
//   issue_instr_o           out  oldest buffered instruction
//   issue_instr_valid_o     out  issue_instr_o is valid
//   issue_is_ctrl_flow_o    out  control-flow flag of the head entry
//   issue_ack_i             in   issue stage consumed the head entry
//   resolve_branch_i        in   execute stage resolved the pending branch
//   full_o                  out  buffer holds DEPTH entries
//   unresolved_branch_o     out  a control-flow instruction is outstanding
//
// ENTRY_W is the width of one scoreboard entry.
// ---------------------------------------------------------------------------
interface issue_instr_buffer_if #(
    parameter int ENTRY_W = 32
);
    logic               flush_i;
    logic               flush_unissued_instr_i;
    logic [ENTRY_W-1:0] decoded_instr_i;
    logic               decoded_instr_valid_i;
    logic               is_ctrl_flow_i;
    logic               decoded_instr_ack_o;
    logic [ENTRY_W-1:0] issue_instr_o;
    logic               issue_instr_valid_o;
    logic               issue_is_ctrl_flow_o;
    logic               issue_ack_i;
    logic               resolve_branch_i;
    logic               full_o;
    logic               unresolved_branch_o;

    // The buffer itself.
    modport slave (
        input  flush_i,
        input  flush_unissued_instr_i,
        input  decoded_instr_i,
        input  decoded_instr_valid_i,
        input  is_ctrl_flow_i,
        output decoded_instr_ack_o,
        output issue_instr_o,
        output issue_instr_valid_o,
        output issue_is_ctrl_flow_o,
        input  issue_ack_i,
        input  resolve_branch_i,
        output full_o,
        output unresolved_branch_o
    );

    // The surrounding pipeline (decode, issue and execute control).
    modport master (
        output flush_i,
        output flush_unissued_instr_i,
        output decoded_instr_i,
        output decoded_instr_valid_i,
        output is_ctrl_flow_i,
        input  decoded_instr_ack_o,
        input  issue_instr_o,
        input  issue_instr_valid_o,
        input  issue_is_ctrl_flow_o,
        output issue_ack_i,
        output resolve_branch_i,
        input  full_o,
        input  unresolved_branch_o
    );
endinterface

// File: rtl/issue_instr_buffer.sv
// ---------------------------------------------------------------------------
// issue_instr_buffer
//
// Decoded-instruction FIFO between the decode stage and the issue stage.
// Instructions are accepted with a combinational valid/ack handshake and
// stored in a DEPTH-entry circular buffer together with a control-flow bit.
// The oldest entry is presented to the issue stage. Once a control-flow
// entry has been issued, further issue is held off until the execute stage
// reports that the branch is resolved, so at most one branch is in flight.
//
// Ports:
//   clk_i   in  clock
//   rst_ni  in  asynchronous reset, active low
//   bus     slave side of issue_instr_buffer_if (handshakes, flushes,
//           branch resolution, status flags)
//
// Parameters:
//   DEPTH    number of entries, power of 2, at least 2
//   ENTRY_W  width of one scoreboard entry (must match the interface)
// ---------------------------------------------------------------------------
module issue_instr_buffer #(
    parameter int DEPTH   = 4,
    parameter int ENTRY_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    issue_instr_buffer_if.slave   bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Pointer arithmetic relies on natural wrap, so DEPTH must be 2^n.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
        $error("issue_instr_buffer: DEPTH must be a power of 2 and >= 2");
    end

    typedef logic [PTR_W-1:0]   ptr_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [ENTRY_W-1:0] entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t             instr_mem [DEPTH];
    logic [DEPTH-1:0]   ctrl_mem;
    ptr_t               rd_ptr_q;
    ptr_t               wr_ptr_q;
    cnt_t               count_q;
    logic               branch_pending_q;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic any_flush;
    logic not_full;
    logic not_empty;
    logic push;
    logic issue_valid;
    logic pop;
    logic head_ctrl;

    always_comb begin
        any_flush   = bus.flush_i | bus.flush_unissued_instr_i;
        not_full    = (count_q < cnt_t'(DEPTH));
        not_empty   = (count_q != '0);
        // Acceptance only looks at the current occupancy: a pop in the same
        // cycle does not free a slot for the incoming instruction.
        push        = bus.decoded_instr_valid_i & not_full & ~any_flush;
        // Issue is held off while a branch is outstanding and in any flush
        // cycle, so a flush never coincides with a pop.
        issue_valid = not_empty & ~branch_pending_q & ~any_flush;
        pop         = issue_valid & bus.issue_ack_i;
        head_ctrl   = ctrl_mem[rd_ptr_q];
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The head entry is always driven from storage; while the buffer is
    // empty this is stale data qualified off by issue_instr_valid_o.
    assign bus.decoded_instr_ack_o  = push;
    assign bus.issue_instr_o        = instr_mem[rd_ptr_q];
    assign bus.issue_is_ctrl_flow_o = head_ctrl;
    assign bus.issue_instr_valid_o  = issue_valid;
    assign bus.full_o               = (count_q == cnt_t'(DEPTH));
    assign bus.unresolved_branch_o  = branch_pending_q;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // Storage is cleared on reset so the head output reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem[i] <= '0;
            end
            ctrl_mem <= '0;
        end else if (push) begin
            instr_mem[wr_ptr_q] <= bus.decoded_instr_i;
            ctrl_mem[wr_ptr_q]  <= bus.is_ctrl_flow_i;
        end
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------
    // Full and empty both have rd_ptr == wr_ptr; the counter tells them apart.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (any_flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Branch gating
    // ------------------------------------------------------------------
    // Issuing a control-flow entry takes priority over a resolve arriving in
    // the same cycle: that resolve belongs to an older branch, and the newly
    // issued one must still be waited for. A partial flush keeps the flag
    // because the branch is already in execute.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_pending_q <= 1'b0;
        end else if (bus.flush_i) begin
            branch_pending_q <= 1'b0;
        end else if (pop && head_ctrl) begin
            branch_pending_q <= 1'b1;
        end else if (bus.resolve_branch_i) begin
            branch_pending_q <= 1'b0;
        end
    end

endmodule

// File: doc/issue_instr_buffer.md
Name: issue_instr_buffer

Overview:
- Decoded-instruction buffer between the decode stage and the issue stage.
- Captures decoded instructions from the id_stage with a valid/ack handshake and stores them in a DEPTH-entry FIFO.
- Presents the oldest entry to the issue stage's rename/scoreboard input.
- Branch gating: after a control-flow instruction is handed downstream, issue of further instructions stops until the execute stage reports that the branch is resolved.

Parameters:
- DEPTH, 4: number of FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active low
- flush_i  in  1  full flush: empty the FIFO and clear the branch-pending state
- flush_unissued_instr_i  in  1  empty the FIFO only; branch-pending state is kept
- decoded_instr_i  in  $bits(scoreboard_entry_t)  decoded instruction from decode
- decoded_instr_valid_i  in  1  decoded_instr_i is valid
- is_ctrl_flow_i  in  1  decoded_instr_i is a branch or jump
- decoded_instr_ack_o  out  1  instruction accepted this cycle
- issue_instr_o  out  $bits(scoreboard_entry_t)  oldest buffered instruction
- issue_instr_valid_o  out  1  issue_instr_o is valid
- issue_is_ctrl_flow_o  out  1  control-flow flag of the head entry
- issue_ack_i  in  1  issue stage consumed the head entry
- resolve_branch_i  in  1  execute stage resolved the outstanding branch
- full_o  out  1  count == DEPTH
- unresolved_branch_o  out  1  branch-pending flag

Behaviour:
- State:
  - DEPTH x (scoreboard_entry_t + ctrl bit) storage.
  - Read and write pointers, clog2(DEPTH) bits each, wrapping modulo DEPTH.
  - Occupancy counter, clog2(DEPTH)+1 bits.
  - branch_pending_q flag.
- Reset:
  - Pointers, count and branch_pending_q are 0.
  - All outputs are 0. issue_instr_o reads stale storage, but storage is reset to 0 as well.
- Push:
  - decoded_instr_ack_o = decoded_instr_valid_i & (count < DEPTH) & ~flush_i & ~flush_unissued_instr_i.
  - Ack is combinational and does not depend on issue_ack_i. No bypass: when full, ack stays low even if a pop happens in the same cycle.
  - On ack, write the entry and ctrl bit at the write pointer, then increment it.
- Head output:
  - issue_instr_o and issue_is_ctrl_flow_o are driven from the read-pointer entry whenever count > 0.
- Valid:
  - issue_instr_valid_o = (count > 0) & ~branch_pending_q & ~flush_i & ~flush_unissued_instr_i.
- Pop:
  - A pop happens when issue_instr_valid_o & issue_ack_i; the read pointer increments.
  - issue_ack_i while valid is low is ignored.
- Latency:
  - An instruction pushed in cycle N is visible on the issue outputs in cycle N+1 at the earliest.
  - Simultaneous push and pop leaves count unchanged.
- Branch gating:
  - Popping an entry with ctrl=1 sets branch_pending_q in the next cycle.
  - While branch_pending_q is set, issue_instr_valid_o is forced low; pushes continue until the FIFO is full.
  - resolve_branch_i clears branch_pending_q in the next cycle, so issue resumes one cycle after resolve.
  - If set and resolve occur in the same cycle, set wins, so at most one branch is outstanding.
  - resolve_branch_i while nothing is pending has no effect.
- Flush:
  - flush_i takes effect in the next cycle: pointers, count and branch_pending_q go to 0.
  - flush_unissued_instr_i takes effect in the next cycle: pointers and count go to 0; branch_pending_q is kept.
  - No push and no pop happens in a flush cycle.
  - flush_i has priority when both flushes are asserted.
- Wrap-around:
  - Pointers wrap silently.
  - full_o and an empty FIFO are distinguished by count, not by the pointers.
- Reset mid-operation: asynchronous reset returns all state to reset values immediately, regardless of the handshake in progress.

Test Plan:
- Fill and drain:
  - Stimulus: push A, B, C, D on consecutive cycles with issue_ack_i = 0.
  - Required: ack high for 4 cycles; full_o = 1 after the 4th; a 5th valid input gets ack = 0.
  - Then set issue_ack_i = 1: outputs A, B, C, D in order, one per cycle; count returns to 0.
- Streaming and wrap-around:
  - Stimulus: continuous push with continuous issue_ack_i for 10 instructions (IDs 0..9).
  - Required: every instruction issued in order with 1-cycle latency; pointers wrap twice; full_o never asserted.
- Branch gating:
  - Stimulus: push BR (ctrl = 1) then X and Y; issue_ack_i = 1.
  - Required: BR issues; valid is low while unresolved_branch_o = 1.
  - Pulse resolve_branch_i 3 cycles later: X is valid the cycle after the pulse, then Y.
- Flush variants:
  - Stimulus: 3 entries held and a branch pending; assert flush_unissued_instr_i.
  - Required: count = 0, unresolved_branch_o stays 1.
  - Repeat with flush_i: count = 0, unresolved_branch_o = 0.
  - Assert a push in the flush cycle: ack = 0 and nothing is stored.
- Corner handshakes:
  - Full FIFO with simultaneous pop and valid input: ack = 0, count goes to 3.
  - Set and resolve in the same cycle: branch pending remains 1.
  - issue_ack_i with the FIFO empty: no pointer change.
- Async reset:
  - Stimulus: assert rst_ni low mid-stream with 2 entries held and a branch pending.
  - Required: all outputs 0 immediately. After release, the first push appears one cycle later.
